// File: rtl/mips_pkg.sv
// mips_pkg
// Shared definitions for the MIPS32 boot-time program loader.
//   ld_state_e : loader FSM state encoding (IDLE, LOAD, CHECK, DONE, ERROR)
//   ERR_*      : values driven on the loader err output
//   OP_HLT     : MIPS32 halt opcode, for building test programs
package mips_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CHECK = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } ld_state_e;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_RANGE = 2'b01;
    localparam logic [1:0] ERR_CSUM  = 2'b10;

    localparam logic [5:0] OP_HLT = 6'h3f;

endpackage

// File: rtl/mips_ld_csum.sv
// mips_ld_csum
// Running modulo-2**DATA_W sum of the program words in a frame. The sum is
// compared against the frame trailer.
//   clk1      : clock, rising edge
//   rst_n     : synchronous active-low reset (sum -> 0)
//   clr       : force the sum to 0 on the next edge (takes priority over en)
//   en        : add add_data into the sum on the next edge
//   add_data  : word to accumulate
//   cmp_data  : word to compare against the current sum
//   match     : 1 when cmp_data equals the current sum
module mips_ld_csum #(
    parameter int DATA_W = 32
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] add_data,
    input  logic [DATA_W-1:0] cmp_data,
    output logic              match
);

    logic [DATA_W-1:0] sum_q;
    logic [DATA_W-1:0] sum_d;

    always_comb begin
        sum_d = sum_q;
        if (clr) begin
            sum_d = '0;
        end else if (en) begin
            sum_d = sum_q + add_data;
        end
    end

    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign match = (cmp_data == sum_q);

endmodule

// File: rtl/mips_prog_loader.sv
// mips_prog_loader
// Boot loader in front of the mips_32 pipeline. Receives a framed word stream
// (header, program words, checksum trailer), writes each program word into the
// core memory port while the core is held, then releases the core at boot_pc.
//   clk1, rst_n          : clock and synchronous active-low reset
//   in_valid/in_data     : host word stream; transfer on in_valid & in_ready
//   in_ready             : loader can accept a word (IDLE, LOAD, CHECK)
//   mem_we/addr/wdata    : one-cycle write strobe into core memory
//   core_hold            : 1 keeps the core halted
//   core_start           : one-cycle release pulse on entering DONE
//   boot_pc              : core start address, valid from core_start onward
//   done, err            : frame verified / error code (see mips_pkg)
//   restart              : from DONE or ERROR, return to IDLE
// Header word: [31:16] start address, [15:0] word count.
module mips_prog_loader
    import mips_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              core_hold,
    output logic              core_start,
    output logic [ADDR_W-1:0] boot_pc,
    output logic              done,
    output logic [1:0]        err,
    input  logic              restart
);

    // Memory depth expressed in the 17-bit width used for range checks.
    localparam logic [16:0] DEPTH = 17'd1 << ADDR_W;

    ld_state_e         state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [15:0]       rem_q, rem_d;
    logic [ADDR_W-1:0] start_q, start_d;
    logic [ADDR_W-1:0] boot_pc_q, boot_pc_d;
    logic [1:0]        err_q, err_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              core_start_q, core_start_d;
    logic              in_ready_q, in_ready_d;

    logic              xfer;
    logic [15:0]       hdr_start;
    logic [15:0]       hdr_cnt;
    logic [16:0]       hdr_end;
    logic              hdr_bad;
    logic              csum_clr;
    logic              csum_en;
    logic              csum_match;

    assign xfer      = in_valid & in_ready_q;
    assign hdr_start = in_data[31:16];
    assign hdr_cnt   = in_data[15:0];
    // Both the start address and the end of the span are checked in 17 bits
    // so a huge count cannot wrap back into range.
    assign hdr_end   = {1'b0, hdr_start} + {1'b0, hdr_cnt};
    assign hdr_bad   = ({1'b0, hdr_start} >= DEPTH) || (hdr_end > DEPTH);

    mips_ld_csum #(
        .DATA_W(DATA_W)
    ) u_csum (
        .clk1    (clk1),
        .rst_n   (rst_n),
        .clr     (csum_clr),
        .en      (csum_en),
        .add_data(in_data),
        .cmp_data(in_data),
        .match   (csum_match)
    );

    // Next-state and datapath updates. mem_we is a pulse; address and data
    // hold their last value between writes.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        rem_d        = rem_q;
        start_d      = start_q;
        boot_pc_d    = boot_pc_q;
        err_d        = err_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        core_start_d = 1'b0;
        csum_clr     = 1'b0;
        csum_en      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    start_d  = hdr_start[ADDR_W-1:0];
                    ptr_d    = hdr_start[ADDR_W-1:0];
                    rem_d    = hdr_cnt;
                    csum_clr = 1'b1;
                    if (hdr_bad) begin
                        state_d = ST_ERROR;
                        err_d   = ERR_RANGE;
                    end else if (hdr_cnt == 16'd0) begin
                        state_d = ST_CHECK;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (xfer) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = ptr_q;
                    mem_wdata_d = in_data;
                    csum_en     = 1'b1;
                    ptr_d       = ptr_q + ADDR_W'(1);
                    rem_d       = rem_q - 16'd1;
                    if (rem_q == 16'd1) begin
                        state_d = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                if (xfer) begin
                    if (csum_match) begin
                        state_d      = ST_DONE;
                        boot_pc_d    = start_q;
                        core_start_d = 1'b1;
                    end else begin
                        state_d = ST_ERROR;
                        err_d   = ERR_CSUM;
                    end
                end
            end
            ST_DONE, ST_ERROR: begin
                if (restart) begin
                    state_d = ST_IDLE;
                    err_d   = ERR_NONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Registered ready follows the state being entered, so it is low
        // throughout reset and rises with the first IDLE cycle.
        in_ready_d = (state_d == ST_IDLE) || (state_d == ST_LOAD) ||
                     (state_d == ST_CHECK);
    end

    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            rem_q        <= '0;
            start_q      <= '0;
            boot_pc_q    <= '0;
            err_q        <= ERR_NONE;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            core_start_q <= 1'b0;
            in_ready_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            rem_q        <= rem_d;
            start_q      <= start_d;
            boot_pc_q    <= boot_pc_d;
            err_q        <= err_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            core_start_q <= core_start_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign core_start = core_start_q;
    assign boot_pc    = boot_pc_q;
    assign err        = err_q;
    assign done       = (state_q == ST_DONE);
    assign core_hold  = (state_q != ST_DONE);

endmodule

// File: tb/tb_mips_prog_loader.sv
// tb_mips_prog_loader
// Directed bench for mips_prog_loader: basic load, bubbles with an offset,
// range error, checksum error, zero-count frame and reset during LOAD.
module tb_mips_prog_loader;
    import mips_pkg::*;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;

    logic              clk1;
    logic              rst_n;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              core_hold;
    logic              core_start;
    logic [ADDR_W-1:0] boot_pc;
    logic              done;
    logic [1:0]        err;
    logic              restart;

    int errors = 0;
    int checks = 0;

    // Write and release-pulse log, filled by the monitor below.
    logic [31:0] wr_addr [64];
    logic [31:0] wr_data [64];
    int          we_total = 0;
    int          cs_total = 0;

    int          we_base;
    int          cs_base;
    logic [31:0] hlt_word;

    mips_prog_loader #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) dut (
        .clk1      (clk1),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .core_hold (core_hold),
        .core_start(core_start),
        .boot_pc   (boot_pc),
        .done      (done),
        .err       (err),
        .restart   (restart)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    // Sample on the falling edge, away from the active edge.
    always @(negedge clk1) begin
        if (mem_we) begin
            if (we_total < 64) begin
                wr_addr[we_total] <= 32'(mem_addr);
                wr_data[we_total] <= mem_wdata;
            end
            we_total <= we_total + 1;
        end
        if (core_start) begin
            cs_total <= cs_total + 1;
        end
    end

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present one word and hold it until accepted; optionally leave a bubble.
    task automatic applyStimulus(input logic [31:0] w, input bit bubble);
        bit accepted;
        accepted = 1'b0;
        in_valid = 1'b1;
        in_data  = w;
        for (int i = 0; i < 20; i++) begin
            if (in_ready) begin
                accepted = 1'b1;
                tick();
                break;
            end
            tick();
        end
        in_valid = 1'b0;
        checkOutput("handshake", 32'(accepted), 32'd1);
        if (bubble) begin
            tick();
        end
    endtask

    task automatic doRestart();
        restart = 1'b1;
        tick();
        restart = 1'b0;
    endtask

    task automatic checkResetValues(input string tag);
        $display("[TB] reset values: %s", tag);
        checkOutput("rst core_hold", 32'(core_hold), 32'd1);
        checkOutput("rst in_ready", 32'(in_ready), 32'd0);
        checkOutput("rst mem_we", 32'(mem_we), 32'd0);
        checkOutput("rst mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("rst mem_wdata", mem_wdata, 32'd0);
        checkOutput("rst core_start", 32'(core_start), 32'd0);
        checkOutput("rst boot_pc", 32'(boot_pc), 32'd0);
        checkOutput("rst done", 32'(done), 32'd0);
        checkOutput("rst err", 32'(err), 32'd0);
    endtask

    initial begin
        hlt_word = {OP_HLT, 26'd0};
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        restart  = 1'b0;
        tick();
        tick();
        checkResetValues("power-on");
        rst_n = 1'b1;
        tick();
        checkOutput("idle in_ready", 32'(in_ready), 32'd1);

        // 1: basic load at address 0
        $display("[TB] test 1: basic load");
        we_base = we_total;
        cs_base = cs_total;
        applyStimulus(32'h0000_0002, 1'b0);
        applyStimulus(32'h2801_000a, 1'b0);
        checkOutput("t1 we latency", 32'(mem_we), 32'd1);
        checkOutput("t1 addr0 live", 32'(mem_addr), 32'd0);
        checkOutput("t1 data0 live", mem_wdata, 32'h2801_000a);
        applyStimulus(hlt_word, 1'b0);
        checkOutput("t1 hold in load", 32'(core_hold), 32'd1);
        applyStimulus(32'h2401_000a, 1'b0);
        checkOutput("t1 core_start", 32'(core_start), 32'd1);
        checkOutput("t1 done", 32'(done), 32'd1);
        checkOutput("t1 core_hold", 32'(core_hold), 32'd0);
        checkOutput("t1 boot_pc", 32'(boot_pc), 32'd0);
        checkOutput("t1 err", 32'(err), 32'd0);
        checkOutput("t1 in_ready", 32'(in_ready), 32'd0);
        tick();
        checkOutput("t1 start pulse end", 32'(core_start), 32'd0);
        checkOutput("t1 done held", 32'(done), 32'd1);
        checkOutput("t1 write count", 32'(we_total - we_base), 32'd2);
        checkOutput("t1 wr0 addr", wr_addr[we_base], 32'd0);
        checkOutput("t1 wr0 data", wr_data[we_base], 32'h2801_000a);
        checkOutput("t1 wr1 addr", wr_addr[we_base+1], 32'd1);
        checkOutput("t1 wr1 data", wr_data[we_base+1], 32'hfc00_0000);
        checkOutput("t1 start count", 32'(cs_total - cs_base), 32'd1);
        doRestart();
        checkOutput("t1 restart done", 32'(done), 32'd0);
        checkOutput("t1 restart hold", 32'(core_hold), 32'd1);
        checkOutput("t1 restart ready", 32'(in_ready), 32'd1);

        // 2: bubbles between every word, start address 16
        $display("[TB] test 2: bubbles and offset");
        we_base = we_total;
        cs_base = cs_total;
        applyStimulus(32'h0010_0002, 1'b1);
        applyStimulus(32'h2801_000a, 1'b1);
        applyStimulus(hlt_word, 1'b1);
        applyStimulus(32'h2401_000a, 1'b0);
        checkOutput("t2 done", 32'(done), 32'd1);
        checkOutput("t2 boot_pc", 32'(boot_pc), 32'd16);
        tick();
        checkOutput("t2 write count", 32'(we_total - we_base), 32'd2);
        checkOutput("t2 wr0 addr", wr_addr[we_base], 32'd16);
        checkOutput("t2 wr1 addr", wr_addr[we_base+1], 32'd17);
        checkOutput("t2 wr1 data", wr_data[we_base+1], 32'hfc00_0000);
        checkOutput("t2 start count", 32'(cs_total - cs_base), 32'd1);
        doRestart();

        // 3: span runs past the top of memory
        $display("[TB] test 3: range error");
        we_base = we_total;
        applyStimulus(32'h03FF_0002, 1'b0);
        checkOutput("t3 err", 32'(err), 32'(ERR_RANGE));
        checkOutput("t3 in_ready", 32'(in_ready), 32'd0);
        tick();
        tick();
        tick();
        checkOutput("t3 err held", 32'(err), 32'd1);
        checkOutput("t3 core_hold", 32'(core_hold), 32'd1);
        checkOutput("t3 done", 32'(done), 32'd0);
        checkOutput("t3 write count", 32'(we_total - we_base), 32'd0);
        doRestart();
        checkOutput("t3 restart err", 32'(err), 32'd0);
        checkOutput("t3 restart ready", 32'(in_ready), 32'd1);

        // 4: trailer off by one
        $display("[TB] test 4: checksum error");
        we_base = we_total;
        cs_base = cs_total;
        applyStimulus(32'h0000_0002, 1'b0);
        applyStimulus(32'h2801_000a, 1'b0);
        applyStimulus(hlt_word, 1'b0);
        applyStimulus(32'h2401_000b, 1'b0);
        checkOutput("t4 err", 32'(err), 32'd2);
        checkOutput("t4 core_hold", 32'(core_hold), 32'd1);
        tick();
        checkOutput("t4 write count", 32'(we_total - we_base), 32'd2);
        checkOutput("t4 start count", 32'(cs_total - cs_base), 32'd0);
        doRestart();

        // 5: empty program at address 5
        $display("[TB] test 5: zero count");
        we_base = we_total;
        applyStimulus(32'h0005_0000, 1'b0);
        applyStimulus(32'h0000_0000, 1'b0);
        checkOutput("t5 done", 32'(done), 32'd1);
        checkOutput("t5 boot_pc", 32'(boot_pc), 32'd5);
        checkOutput("t5 core_start", 32'(core_start), 32'd1);
        tick();
        checkOutput("t5 write count", 32'(we_total - we_base), 32'd0);
        doRestart();

        // 6: reset right after the first data word, then a clean frame
        $display("[TB] test 6: reset mid-load");
        applyStimulus(32'h0000_0002, 1'b0);
        applyStimulus(32'h2801_000a, 1'b0);
        rst_n = 1'b0;
        tick();
        checkResetValues("mid-load");
        rst_n = 1'b1;
        tick();
        we_base = we_total;
        applyStimulus(32'h0000_0002, 1'b0);
        applyStimulus(32'h2801_000a, 1'b0);
        applyStimulus(hlt_word, 1'b0);
        applyStimulus(32'h2401_000a, 1'b0);
        checkOutput("t6 done", 32'(done), 32'd1);
        checkOutput("t6 err", 32'(err), 32'd0);
        tick();
        checkOutput("t6 write count", 32'(we_total - we_base), 32'd2);
        checkOutput("t6 wr1 addr", wr_addr[we_base+1], 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
